// File: rtl/vsynth_voice_pkg.sv
// Shared types for the voice allocator.
//   NOTE_W_DEF  : default note-number width
//   slot_cls_e  : per-voice classification (FREE / HELD / RELEASED)
//   alloc_st_e  : allocator FSM states (IDLE / SCAN / ISSUE)
//   victim_src_e: where the chosen voice came from
package vsynth_voice_pkg;

  localparam int NOTE_W_DEF = 7;

  typedef enum logic [1:0] {
    CLS_FREE = 2'd0,
    CLS_HELD = 2'd1,
    CLS_REL  = 2'd2
  } slot_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2
  } alloc_st_e;

  typedef enum logic [2:0] {
    SRC_MATCH = 3'd0,
    SRC_FREE  = 3'd1,
    SRC_REL   = 3'd2,
    SRC_HELD  = 3'd3,
    SRC_NONE  = 3'd4
  } victim_src_e;

endpackage

// File: rtl/voice_allocator_slot.sv
// voice_slot: per-voice bookkeeping (note, held flag, saturating age).
//   clk, rst        : clock, synchronous active-high reset
//   voice_idle_i    : envelope of this voice is finished
//   load_i          : assign note_i to this voice (held=1, age=0)
//   release_i       : clear held
//   age_inc_i       : bump age, saturating at 2^AGE_W-1
//   note_i          : note to load
//   cls_o           : FREE / HELD / RELEASED classification
//   note_o, age_o   : current note and age
module voice_slot
  import vsynth_voice_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int AGE_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              voice_idle_i,
  input  logic              load_i,
  input  logic              release_i,
  input  logic              age_inc_i,
  input  logic [NOTE_W-1:0] note_i,
  output slot_cls_e         cls_o,
  output logic [NOTE_W-1:0] note_o,
  output logic [AGE_W-1:0]  age_o
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic              held_q;
  logic [NOTE_W-1:0] note_q;
  logic [AGE_W-1:0]  age_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= 1'b0;
      note_q <= '0;
      age_q  <= '0;
    end else if (load_i) begin
      held_q <= 1'b1;
      note_q <= note_i;
      age_q  <= '0;
    end else begin
      if (release_i) held_q <= 1'b0;
      if (age_inc_i && age_q != AGE_MAX) age_q <= age_q + 1'b1;
    end
  end

  // Held dominates: a held voice is never FREE even if its envelope idles.
  always_comb begin
    cls_o = CLS_REL;
    if (held_q)            cls_o = CLS_HELD;
    else if (voice_idle_i) cls_o = CLS_FREE;
  end

  assign note_o = note_q;
  assign age_o  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: polyphony scheduler in front of NUM_VOICES envelopes.
// Accepts note-on/off events, scans one voice per cycle, then issues a
// single one-cycle gate_on/gate_off strobe.
//   clk, rst      : clock, synchronous active-high reset
//   evt_valid/evt_ready, evt_is_on, evt_note : event handshake
//   voice_idle    : per-voice envelope finished
//   gate_on/off   : per-voice one-cycle strobes (registered)
//   voice_note    : note per voice, voice i at [i*NOTE_W +: NOTE_W]
//   evt_dropped   : note-on discarded (no match/free voice)
// Build option VALLOC_STEAL_EN: steal oldest released, else oldest held
// voice instead of dropping; evt_dropped is then tied to 0.
module voice_allocator
  import vsynth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int AGE_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         evt_valid,
  output logic                         evt_ready,
  input  logic                         evt_is_on,
  input  logic [NOTE_W-1:0]            evt_note,
  input  logic [NUM_VOICES-1:0]        voice_idle,
  output logic [NUM_VOICES-1:0]        gate_on,
  output logic [NUM_VOICES-1:0]        gate_off,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic                         evt_dropped
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

  alloc_st_e         state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              on_q;
  logic [NOTE_W-1:0] note_q;
  logic              match_f_q, free_f_q;
  logic [IDX_W-1:0]  match_idx_q, free_idx_q;
  logic [NUM_VOICES-1:0] gate_on_q, gate_off_q;

  slot_cls_e [NUM_VOICES-1:0]              cls_w;
  logic      [NUM_VOICES-1:0][NOTE_W-1:0]  note_w;
  logic      [NUM_VOICES-1:0][AGE_W-1:0]   age_w;
  logic      [NUM_VOICES-1:0]              ld_w, rl_w, inc_w;

  victim_src_e       src;
  logic [IDX_W-1:0]  vidx;

  slot_cls_e         cur_cls;
  logic [NOTE_W-1:0] cur_note;
  logic              cur_match;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(.NOTE_W(NOTE_W), .AGE_W(AGE_W)) u_slot (
      .clk          (clk),
      .rst          (rst),
      .voice_idle_i (voice_idle[i]),
      .load_i       (ld_w[i]),
      .release_i    (rl_w[i]),
      .age_inc_i    (inc_w[i]),
      .note_i       (note_q),
      .cls_o        (cls_w[i]),
      .note_o       (note_w[i]),
      .age_o        (age_w[i])
    );
  end

  assign voice_note = note_w;
  assign evt_ready  = (state_q == ST_IDLE);
  assign gate_on    = gate_on_q;
  assign gate_off   = gate_off_q;

  // Slot under examination; voice_idle is live so class reflects this cycle.
  assign cur_cls  = cls_w[idx_q];
  assign cur_note = note_w[idx_q];
  // Note-on retriggers a held or released voice; note-off only hits held ones.
  assign cur_match = (cur_note == note_q) &&
                     (on_q ? (cur_cls != CLS_FREE) : (cur_cls == CLS_HELD));

`ifdef VALLOC_STEAL_EN
  logic             rel_f_q, hld_f_q;
  logic [IDX_W-1:0] rel_idx_q, hld_idx_q;
  logic [AGE_W-1:0] rel_age_q, hld_age_q;
  logic [AGE_W-1:0] cur_age;

  assign cur_age     = age_w[idx_q];
  assign evt_dropped = 1'b0;
`else
  logic drop_q;
  logic unused_age;

  assign unused_age  = ^age_w;
  assign evt_dropped = drop_q;
`endif

  // Victim selection from the candidate registers, used during ISSUE.
  always_comb begin
    src  = SRC_NONE;
    vidx = '0;
    if (match_f_q) begin
      src  = SRC_MATCH;
      vidx = match_idx_q;
    end else if (on_q && free_f_q) begin
      src  = SRC_FREE;
      vidx = free_idx_q;
    end
`ifdef VALLOC_STEAL_EN
    else if (on_q && rel_f_q) begin
      src  = SRC_REL;
      vidx = rel_idx_q;
    end else if (on_q && hld_f_q) begin
      src  = SRC_HELD;
      vidx = hld_idx_q;
    end
`endif
  end

  always_comb begin
    ld_w  = '0;
    rl_w  = '0;
    inc_w = '0;
    if (state_q == ST_ISSUE && src != SRC_NONE) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (vidx == IDX_W'(i)) begin
          ld_w[i] = on_q;
          rl_w[i] = !on_q;
        end else begin
          inc_w[i] = on_q && (cls_w[i] != CLS_FREE);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      match_f_q   <= 1'b0;
      free_f_q    <= 1'b0;
      match_idx_q <= '0;
      free_idx_q  <= '0;
      gate_on_q   <= '0;
      gate_off_q  <= '0;
`ifdef VALLOC_STEAL_EN
      rel_f_q     <= 1'b0;
      hld_f_q     <= 1'b0;
      rel_idx_q   <= '0;
      hld_idx_q   <= '0;
      rel_age_q   <= '0;
      hld_age_q   <= '0;
`else
      drop_q      <= 1'b0;
`endif
    end else begin
      gate_on_q  <= '0;
      gate_off_q <= '0;
`ifndef VALLOC_STEAL_EN
      drop_q     <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (evt_valid) begin
            state_q   <= ST_SCAN;
            idx_q     <= '0;
            on_q      <= evt_is_on;
            note_q    <= evt_note;
            match_f_q <= 1'b0;
            free_f_q  <= 1'b0;
`ifdef VALLOC_STEAL_EN
            rel_f_q   <= 1'b0;
            hld_f_q   <= 1'b0;
`endif
          end
        end
        ST_SCAN: begin
          if (!match_f_q && cur_match) begin
            match_f_q   <= 1'b1;
            match_idx_q <= idx_q;
          end
          if (!free_f_q && cur_cls == CLS_FREE) begin
            free_f_q   <= 1'b1;
            free_idx_q <= idx_q;
          end
`ifdef VALLOC_STEAL_EN
          // Strict '>' keeps the lower index on equal (incl. saturated) ages.
          if (cur_cls == CLS_REL && (!rel_f_q || cur_age > rel_age_q)) begin
            rel_f_q   <= 1'b1;
            rel_idx_q <= idx_q;
            rel_age_q <= cur_age;
          end
          if (cur_cls == CLS_HELD && (!hld_f_q || cur_age > hld_age_q)) begin
            hld_f_q   <= 1'b1;
            hld_idx_q <= idx_q;
            hld_age_q <= cur_age;
          end
`endif
          if (idx_q == IDX_LAST) state_q <= ST_ISSUE;
          else                   idx_q   <= idx_q + 1'b1;
        end
        ST_ISSUE: begin
          gate_on_q  <= ld_w;
          gate_off_q <= rl_w;
`ifndef VALLOC_STEAL_EN
          drop_q     <= on_q && (src == SRC_NONE);
`endif
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony scheduler in front of NUM_VOICES ADSR envelope channels.
- Accepts note-on/note-off events from the MIDI/event front end and assigns each note-on to one voice.
- Drives each voice's one-cycle gate_on/gate_off strobes, which start and stop that voice's envelope.
- Sequential scan FSM: examines one voice per cycle, then issues a strobe, so comparator cost stays constant as NUM_VOICES grows.

Parameters:
- NUM_VOICES, 8, number of voice slots; 2..16.
- NOTE_W, 7, note number width.
- AGE_W, 4, per-voice age counter width; saturates at 2^AGE_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- evt_valid  in  1  event present
- evt_ready  out  1  allocator can accept an event
- evt_is_on  in  1  1 = note-on, 0 = note-off
- evt_note  in  NOTE_W  note number
- voice_idle  in  NUM_VOICES  per voice, 1 = envelope in IDLE (finished)
- gate_on  out  NUM_VOICES  one-cycle strobe per voice
- gate_off  out  NUM_VOICES  one-cycle strobe per voice
- voice_note  out  NUM_VOICES*NOTE_W  note assigned to each voice; voice i at bits [i*NOTE_W +: NOTE_W]
- evt_dropped  out  1  one-cycle strobe: note-on discarded

Behaviour:
- Reset: FSM = IDLE; per slot held=0, note=0, age=0; gate_on=0, gate_off=0, evt_dropped=0; evt_ready=1.
- Reset mid-scan abandons the event silently. No strobe is issued.
- Handshake: an event is accepted on a clock edge where evt_valid && evt_ready. evt_note and evt_is_on are latched on that edge.
- evt_ready = 1 only in state IDLE.
- Slot classes, evaluated combinationally per slot:
  - HELD: held=1.
  - FREE: held=0 && voice_idle=1.
  - RELEASED: held=0 && voice_idle=0.
- State IDLE: on accept, go to SCAN with idx=0 and clear the candidate registers.
- State SCAN: one slot per cycle, idx = 0..NUM_VOICES-1. Candidates are tracked in registers:
  - match: first HELD or RELEASED slot whose note == latched note.
  - free: first FREE slot.
  - oldest released: largest age; tie goes to the lower index.
  - oldest held: largest age; tie goes to the lower index.
  - After idx = NUM_VOICES-1, go to ISSUE.
- State ISSUE: exactly one cycle, then go to IDLE.
- Note-on victim priority: match > free > oldest released > oldest held.
- For the chosen voice v:
  - gate_on[v]=1 for that single cycle.
  - note[v] = latched note; held[v]=1; age[v]=0.
  - Every other slot with held=1 or RELEASED has its age incremented, saturating.
- Note-off: if a HELD slot has a matching note, gate_off[v]=1 and held[v]=0. Otherwise no strobe and no state change. Ages are unchanged.
- Latency: strobe asserted at cycle T+NUM_VOICES+1, where T is the accept edge. The next accept is possible at edge T+NUM_VOICES+2.
- Strobes are registered outputs. All bits are 0 except in ISSUE, and at most one bit across gate_on|gate_off is set.
- voice_idle is sampled live during SCAN. A voice that finishes mid-scan is classified by its state when its own slot is examined.
- Age wrap: saturates and never wraps. Among saturated slots the lower index wins.

Optional Feature:
- VALLOC_STEAL_EN defined: when no match or free slot exists, the victim is the oldest released slot, else the oldest held slot. evt_dropped is tied to 0.
- VALLOC_STEAL_EN undefined: when no match or free slot exists, the note-on is discarded. No gate strobe is issued, no slot state changes, and evt_dropped=1 for the ISSUE cycle. The released/held age comparators are not built.

Decomposition:
- Package vsynth_voice_pkg holds:
  - NOTE_W default.
  - Slot-class encoding (FREE/HELD/RELEASED).
  - Allocator FSM state encoding (IDLE/SCAN/ISSUE).
  - Victim-source encoding (MATCH/FREE/REL/HELD/NONE).
- One sub-module, voice_slot: per-voice registers note/held/age.
  - Inputs: load, release, age_inc.
  - Outputs: class, note, age.
  - voice_allocator instantiates NUM_VOICES of these.

Test Plan (NUM_VOICES=4, AGE_W=4, steal enabled unless stated):
- Reset, then note-on 60 -> gate_on=4'b0001 exactly 5 cycles after the accept edge; voice_note[0]=60; evt_ready low for 5 cycles.
- Note-on 60, 62, 64, 65 with all voice_idle=1 -> voices 0..3 in order. Note-on 67 -> steals voice 0 (age 3, oldest held): gate_on=4'b0001, voice_note[0]=67.
- Note-on 60 (voice 0), then note-off 60 with voice_idle[0] held 0 -> gate_off=4'b0001. Then note-on 60 again -> retrigger voice 0 (match), not voice 1.
- All four held, voice 2 note-off'd with voice_idle[2]=0 (RELEASED), new note-on 70 -> voice 2 chosen over the older held voices.
- Note-off 99 with no matching held voice -> no strobes; ages unchanged.
- VALLOC_STEAL_EN undefined, all four held, note-on 70 -> gate_on=0, evt_dropped pulses 1 cycle, voice_note unchanged.
